// File: rtl/div_root_sched.sv
// div_root_sched: round-robin scheduler that shares one iterative
// divide/square-root engine among NUM_REQ requesters.
//
// Optional feature (compile-time macro DIV_ROOT_SCHED_TIMEOUT_EN):
//   when defined, a watchdog limits WAIT to TIMEOUT_CYC cycles and flags the
//   response with rsp_err; when undefined, rsp_err is tied low and WAIT waits
//   for eng_done indefinitely.
module div_root_sched #(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ-1:0]   req_op,
   input  logic [NUM_REQ*10-1:0] req_data_1,
   input  logic [NUM_REQ*3-1:0] req_data_2,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 eng_start,
   output logic                 eng_op,
   output logic [9:0]           eng_data_1,
   output logic [2:0]           eng_data_2,
   input  logic                 eng_done,
   input  logic [19:0]          eng_result,
   output logic [NUM_REQ-1:0]   rsp_valid,
   output logic [19:0]          rsp_data,
   output logic                 rsp_err,
   output logic                 busy
);

   localparam int IDX_W = $clog2(NUM_REQ);

   // Elaboration-time parameter range checks.
   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("div_root_sched: NUM_REQ must be within 2..8");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("div_root_sched: TIMEOUT_CYC must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] win;

   logic             arb_hit;
   logic [IDX_W-1:0] arb_idx;
   logic [IDX_W:0]   cand;

   logic             sel_op;
   logic [9:0]       sel_d1;
   logic [2:0]       sel_d2;
   logic             sel_div0;

`ifdef DIV_ROOT_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] wd_cnt;
   logic [CNT_W-1:0] wd_nxt;
   assign wd_nxt = wd_cnt + 1'b1;
`else
   assign rsp_err = 1'b0;
`endif

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
      if (idx == IDX_W'(NUM_REQ - 1)) return '0;
      else                            return idx + 1'b1;
   endfunction

   // Round-robin search: first pending request at or above rr_ptr, wrapping.
   always_comb begin
      arb_hit = 1'b0;
      arb_idx = '0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
         if (!arb_hit && req[cand[IDX_W-1:0]]) begin
            arb_hit = 1'b1;
            arb_idx = cand[IDX_W-1:0];
         end
      end
   end

   assign sel_op   = req_op[arb_idx];
   assign sel_d1   = req_data_1[arb_idx*10 +: 10];
   assign sel_d2   = req_data_2[arb_idx*3 +: 3];
   // Only a divide by zero bypasses the engine; a root ignores its divisor.
   assign sel_div0 = !sel_op && (sel_d2 == 3'd0);

   assign busy = (state != IDLE);

   // Scheduler FSM with registered engine launch, grant and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         win        <= '0;
         grant      <= '0;
         eng_start  <= 1'b0;
         eng_op     <= 1'b0;
         eng_data_1 <= '0;
         eng_data_2 <= '0;
         rsp_valid  <= '0;
         rsp_data   <= '0;
`ifdef DIV_ROOT_SCHED_TIMEOUT_EN
         rsp_err    <= 1'b0;
         wd_cnt     <= '0;
`endif
      end else begin
         grant     <= '0;
         eng_start <= 1'b0;
         rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (arb_hit) begin
                  win        <= arb_idx;
                  eng_op     <= sel_op;
                  eng_data_1 <= sel_d1;
                  eng_data_2 <= sel_d2;
                  grant      <= onehot(arb_idx);
                  if (sel_div0) begin
                     state     <= RESP;
                     rsp_valid <= onehot(arb_idx);
                     rsp_data  <= 20'hFFFFF;
`ifdef DIV_ROOT_SCHED_TIMEOUT_EN
                     rsp_err   <= 1'b0;
`endif
                  end else begin
                     state     <= ISSUE;
                     eng_start <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               state <= WAIT;
`ifdef DIV_ROOT_SCHED_TIMEOUT_EN
               wd_cnt <= '0;
`endif
            end
            WAIT: begin
               if (eng_done) begin
                  state     <= RESP;
                  rsp_valid <= onehot(win);
                  rsp_data  <= eng_result;
`ifdef DIV_ROOT_SCHED_TIMEOUT_EN
                  rsp_err   <= 1'b0;
               end else if (wd_nxt == CNT_W'(TIMEOUT_CYC)) begin
                  state     <= RESP;
                  rsp_valid <= onehot(win);
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
               end else begin
                  wd_cnt <= wd_nxt;
`endif
               end
            end
            RESP: begin
               state  <= IDLE;
               rr_ptr <= next_ptr(win);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_root_sched.sv
// tb_div_root_sched: directed bench for div_root_sched with a simple engine
// model (fixed latency after eng_start, programmable result).
module tb_div_root_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [3:0]  req_op;
   logic [39:0] d1;
   logic [11:0] d2;
   logic [3:0]  grant;
   logic        eng_start;
   logic        eng_op;
   logic [9:0]  eng_data_1;
   logic [2:0]  eng_data_2;
   logic        eng_done;
   logic [19:0] eng_result;
   logic [3:0]  rsp_valid;
   logic [19:0] rsp_data;
   logic        rsp_err;
   logic        busy;

   int          total = 0;
   int          bad = 0;
   int          lat = 1;
   int          mcnt = 0;
   logic [19:0] eng_res = '0;
   logic        eng_en = 1'b1;
   logic        stray = 1'b0;

   div_root_sched #(.NUM_REQ(4), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op),
      .req_data_1(d1), .req_data_2(d2), .grant(grant),
      .eng_start(eng_start), .eng_op(eng_op), .eng_data_1(eng_data_1),
      .eng_data_2(eng_data_2), .eng_done(eng_done), .eng_result(eng_result),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Engine model: eng_done pulses 'lat' cycles after the eng_start cycle.
   always @(posedge clk) begin
      if (eng_start)     mcnt <= lat;
      else if (mcnt != 0) mcnt <= mcnt - 1;
   end
   assign eng_done   = (eng_en && mcnt == 1) || stray;
   assign eng_result = eng_res;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0; req_op = '0; stray = 1'b0; eng_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++; if ({grant, eng_start, rsp_valid, busy} !== 10'b0) begin bad++;
         $display("FAIL reset_ctrl got=%b want=0", {grant, eng_start, rsp_valid, busy}); end
      total++; if ({eng_op, eng_data_1, eng_data_2} !== 14'b0) begin bad++;
         $display("FAIL reset_eng got=%h want=0", {eng_op, eng_data_1, eng_data_2}); end
      total++; if ({rsp_data, rsp_err} !== 21'b0) begin bad++;
         $display("FAIL reset_rsp got=%h want=0", {rsp_data, rsp_err}); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++;
         $display("FAIL reset_idle busy got=%b want=0", busy); end
   endtask

   task automatic test_single_div();
      int n;
      do_reset();
      lat = 5; eng_res = 20'h20000;
      req_op = 4'b0000; d1[9:0] = 10'd6; d2[2:0] = 3'd3; req = 4'b0001;
      @(negedge clk);
      total++; if (grant !== 4'b0001 || eng_start !== 1'b1) begin bad++;
         $display("FAIL div_launch grant=%b start=%b want 0001/1", grant, eng_start); end
      total++; if ({eng_op, eng_data_1, eng_data_2} !== {1'b0, 10'd6, 3'd3}) begin bad++;
         $display("FAIL div_operands got=%h want=%h", {eng_op, eng_data_1, eng_data_2}, {1'b0, 10'd6, 3'd3}); end
      req = 4'b0000;
      @(negedge clk);
      n = 1;
      total++; if ({grant, eng_start} !== 5'b0 || busy !== 1'b1 || eng_data_1 !== 10'd6) begin bad++;
         $display("FAIL div_wait grant=%b start=%b busy=%b d1=%0d want 0000/0/1/6", grant, eng_start, busy, eng_data_1); end
      while (rsp_valid == 4'b0 && n < 20) begin @(negedge clk); n++; end
      total++; if (n !== 6) begin bad++;
         $display("FAIL div_latency got=%0d want=6", n); end
      total++; if (rsp_valid !== 4'b0001 || rsp_data !== 20'h20000 || rsp_err !== 1'b0) begin bad++;
         $display("FAIL div_rsp valid=%b data=%h err=%b want 0001/20000/0", rsp_valid, rsp_data, rsp_err); end
      @(negedge clk);
      total++; if (rsp_valid !== 4'b0 || busy !== 1'b0 || rsp_data !== 20'h20000) begin bad++;
         $display("FAIL div_after valid=%b busy=%b data=%h want 0000/0/20000", rsp_valid, busy, rsp_data); end
   endtask

   task automatic test_round_robin();
      int n;
      do_reset();
      lat = 1; req_op = 4'b0000;
      d1 = {10'd40, 10'd30, 10'd20, 10'd10};
      d2 = {3'd1, 3'd2, 3'd3, 3'd4};
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (grant == 4'b0 && n < 20) begin @(negedge clk); n++; end
         total++; if (grant !== (4'b0001 << k)) begin bad++;
            $display("FAIL rr_grant%0d got=%b want=%b", k, grant, 4'b0001 << k); end
         total++; if (eng_data_1 !== 10'(10 * (k + 1)) || eng_data_2 !== 3'(4 - k)) begin bad++;
            $display("FAIL rr_operands%0d got=%0d/%0d want=%0d/%0d", k, eng_data_1, eng_data_2, 10 * (k + 1), 4 - k); end
         eng_res = 20'hA0000 + 20'(k);
         n = 0;
         while (rsp_valid == 4'b0 && n < 20) begin @(negedge clk); n++; end
         total++; if (rsp_valid !== (4'b0001 << k) || rsp_data !== 20'hA0000 + 20'(k)) begin bad++;
            $display("FAIL rr_rsp%0d valid=%b data=%h want=%b/%h", k, rsp_valid, rsp_data, 4'b0001 << k, 20'hA0000 + 20'(k)); end
         req[k] = 1'b0;
      end
      req = 4'b0101;
      n = 0;
      while (grant == 4'b0 && n < 20) begin @(negedge clk); n++; end
      total++; if (grant !== 4'b0001) begin bad++;
         $display("FAIL rr_reraise_first got=%b want=0001", grant); end
      n = 0;
      while (rsp_valid == 4'b0 && n < 20) begin @(negedge clk); n++; end
      req[0] = 1'b0;
      n = 0;
      while (grant == 4'b0 && n < 20) begin @(negedge clk); n++; end
      total++; if (grant !== 4'b0100) begin bad++;
         $display("FAIL rr_reraise_second got=%b want=0100", grant); end
      n = 0;
      while (rsp_valid == 4'b0 && n < 20) begin @(negedge clk); n++; end
      total++; if (rsp_valid !== 4'b0100) begin bad++;
         $display("FAIL rr_reraise_rsp got=%b want=0100", rsp_valid); end
      req = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_div_zero();
      do_reset();
      req_op = 4'b0000; d1[19:10] = 10'd5; d2[5:3] = 3'd0; req = 4'b0010;
      @(negedge clk);
      total++; if (grant !== 4'b0010 || rsp_valid !== 4'b0010) begin bad++;
         $display("FAIL dz_pulse grant=%b valid=%b want 0010/0010", grant, rsp_valid); end
      total++; if (rsp_data !== 20'hFFFFF || rsp_err !== 1'b0) begin bad++;
         $display("FAIL dz_data data=%h err=%b want FFFFF/0", rsp_data, rsp_err); end
      total++; if (eng_start !== 1'b0) begin bad++;
         $display("FAIL dz_no_start got=%b want=0", eng_start); end
      req = 4'b0000;
      @(negedge clk);
      total++; if (rsp_valid !== 4'b0 || busy !== 1'b0 || eng_start !== 1'b0) begin bad++;
         $display("FAIL dz_after valid=%b busy=%b start=%b want 0000/0/0", rsp_valid, busy, eng_start); end
   endtask

   task automatic test_root();
      int n;
      do_reset();
      lat = 3; eng_res = 20'h04000;
      req_op = 4'b1000; d1[39:30] = 10'd16; d2[11:9] = 3'd0; req = 4'b1000;
      @(negedge clk);
      total++; if (eng_start !== 1'b1 || eng_op !== 1'b1 || grant !== 4'b1000 || eng_data_1 !== 10'd16) begin bad++;
         $display("FAIL root_launch start=%b op=%b grant=%b d1=%0d want 1/1/1000/16", eng_start, eng_op, grant, eng_data_1); end
      req = 4'b0000;
      n = 0;
      while (rsp_valid == 4'b0 && n < 20) begin @(negedge clk); n++; end
      total++; if (n !== 4 || rsp_valid !== 4'b1000) begin bad++;
         $display("FAIL root_rsp_timing n=%0d valid=%b want 4/1000", n, rsp_valid); end
      total++; if (rsp_data !== 20'h04000 || rsp_err !== 1'b0) begin bad++;
         $display("FAIL root_rsp_data data=%h err=%b want 04000/0", rsp_data, rsp_err); end
      req_op = 4'b0000;
      @(negedge clk);
   endtask

`ifdef DIV_ROOT_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      eng_en = 1'b0;
      req_op = 4'b0000; d1[29:20] = 10'd7; d2[8:6] = 3'd2; req = 4'b0100;
      @(negedge clk);
      total++; if (grant !== 4'b0100 || eng_start !== 1'b1) begin bad++;
         $display("FAIL to_launch grant=%b start=%b want 0100/1", grant, eng_start); end
      req = 4'b0000;
      n = 0;
      while (rsp_valid == 4'b0 && n < 30) begin @(negedge clk); n++; end
      total++; if (n !== 9 || rsp_valid !== 4'b0100) begin bad++;
         $display("FAIL to_timing n=%0d valid=%b want 9/0100", n, rsp_valid); end
      total++; if (rsp_err !== 1'b1 || rsp_data !== 20'h0) begin bad++;
         $display("FAIL to_flag err=%b data=%h want 1/00000", rsp_err, rsp_data); end
      @(negedge clk);
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      @(negedge clk);
      total++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin bad++;
         $display("FAIL to_stray_done valid=%b busy=%b want 0000/0", rsp_valid, busy); end
      eng_en = 1'b1;
   endtask
`else
   task automatic test_long_wait();
      int n;
      lat = 30; eng_res = 20'h0BEEF;
      req_op = 4'b0000; d1[29:20] = 10'd7; d2[8:6] = 3'd2; req = 4'b0100;
      @(negedge clk);
      req = 4'b0000;
      n = 0;
      while (rsp_valid == 4'b0 && n < 60) begin @(negedge clk); n++; end
      total++; if (n !== 31 || rsp_valid !== 4'b0100) begin bad++;
         $display("FAIL long_wait n=%0d valid=%b want 31/0100", n, rsp_valid); end
      total++; if (rsp_data !== 20'h0BEEF || rsp_err !== 1'b0) begin bad++;
         $display("FAIL long_wait_data data=%h err=%b want 0BEEF/0", rsp_data, rsp_err); end
      @(negedge clk);
   endtask
`endif

   task automatic test_reset_mid();
      int n;
      int seen;
      do_reset();
      lat = 1; eng_res = 20'h12345;
      req_op = 4'b0000; d1[19:10] = 10'd9; d2[5:3] = 3'd1; req = 4'b0010;
      n = 0;
      while (rsp_valid == 4'b0 && n < 20) begin @(negedge clk); n++; end
      req = 4'b0000;
      total++; if (rsp_valid !== 4'b0010 || rsp_data !== 20'h12345) begin bad++;
         $display("FAIL rm_first valid=%b data=%h want 0010/12345", rsp_valid, rsp_data); end
      @(negedge clk);
      lat = 20; d1[29:20] = 10'd11; d2[8:6] = 3'd1; req = 4'b0100;
      @(negedge clk);
      total++; if (eng_start !== 1'b1 || grant !== 4'b0100) begin bad++;
         $display("FAIL rm_launch start=%b grant=%b want 1/0100", eng_start, grant); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++; if ({grant, eng_start, rsp_valid, busy} !== 10'b0) begin bad++;
         $display("FAIL rm_async_ctrl got=%b want=0", {grant, eng_start, rsp_valid, busy}); end
      total++; if ({eng_op, eng_data_1, eng_data_2, rsp_data, rsp_err} !== 35'b0) begin bad++;
         $display("FAIL rm_async_data got=%h want=0", {eng_op, eng_data_1, eng_data_2, rsp_data, rsp_err}); end
      req = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (rsp_valid != 4'b0 || busy != 1'b0 || eng_start != 1'b0) seen++;
      end
      total++; if (seen !== 0) begin bad++;
         $display("FAIL rm_quiet activity_cycles=%0d want=0", seen); end
      lat = 1; req = 4'b0110;
      n = 0;
      while (grant == 4'b0 && n < 20) begin @(negedge clk); n++; end
      total++; if (grant !== 4'b0010) begin bad++;
         $display("FAIL rm_ptr_cleared grant=%b want=0010", grant); end
      n = 0;
      while (rsp_valid == 4'b0 && n < 20) begin @(negedge clk); n++; end
      req = 4'b0000;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b1;
      req = '0; req_op = '0; d1 = '0; d2 = '0;
      test_reset();
      test_single_div();
      test_round_robin();
      test_div_zero();
      test_root();
`ifdef DIV_ROOT_SCHED_TIMEOUT_EN
      test_timeout();
`else
      test_long_wait();
`endif
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
